// File: rtl/reg_file_4x4.sv
// Register file with one synchronous write port and two combinational read ports (A, B).
// Optional write-through bypass on both read ports when REG_FILE_BYPASS_EN is defined.
module reg_file_4x4 #(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SEL_A,
  input  logic [ADDR_W-1:0] SEL_B,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] SEL_W,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] OUT_A,
  output logic [DATA_W-1:0] OUT_B
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (write_en) begin
      regs_d[SEL_W] = DATA_IN;
    end
  end

  // Reset dominates any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    OUT_A = regs_q[SEL_A];
    OUT_B = regs_q[SEL_B];
`ifdef REG_FILE_BYPASS_EN
    // Forward the in-flight write so readers see it before the edge.
    if (write_en && !rst && (SEL_A == SEL_W)) begin
      OUT_A = DATA_IN;
    end
    if (write_en && !rst && (SEL_B == SEL_W)) begin
      OUT_B = DATA_IN;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_4x4.sv
// Directed self-checking bench for reg_file_4x4; expectations follow the bypass macro setting.
module tb_reg_file_4x4;

  localparam int DW = 4;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic [AW-1:0] SEL_A;
  logic [AW-1:0] SEL_B;
  logic          write_en;
  logic [AW-1:0] SEL_W;
  logic [DW-1:0] DATA_IN;
  logic [DW-1:0] OUT_A;
  logic [DW-1:0] OUT_B;

  int pass_cnt;
  int total_cnt;

  reg_file_4x4 #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_REGS(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .SEL_A   (SEL_A),
    .SEL_B   (SEL_B),
    .write_en(write_en),
    .SEL_W   (SEL_W),
    .DATA_IN (DATA_IN),
    .OUT_A   (OUT_A),
    .OUT_B   (OUT_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at negedge, step through one rising edge, settle 1 ns past it.
  task automatic cycle(input logic we, input logic [AW-1:0] sw, input logic [DW-1:0] din);
    @(negedge clk);
    write_en = we;
    SEL_W    = sw;
    DATA_IN  = din;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [DW-1:0] exp_v;
    // Reset state while rst is held from time zero.
    for (int i = 0; i < 4; i++) begin
      SEL_A = AW'(i);
      SEL_B = AW'(3 - i);
      #1;
      total_cnt++;
      if (OUT_A !== 4'b0000 || OUT_B !== 4'b0000) begin
        $display("FAIL reset_initial sel=%0d: got A=%b B=%b, want 0000/0000", i, OUT_A, OUT_B);
      end else pass_cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1, AW'(i), 4'b1111);
    exp_v = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      SEL_A = AW'(i);
      #1;
      total_cnt++;
      if (OUT_A !== exp_v) begin
        $display("FAIL prefill reg%0d: got %b, want %b", i, OUT_A, exp_v);
      end else pass_cnt++;
    end
    // Assert reset mid-cycle; outputs must clear with no clock edge.
    write_en = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      SEL_A = AW'(i);
      SEL_B = AW'(i);
      #1;
      total_cnt++;
      if (OUT_A !== 4'b0000 || OUT_B !== 4'b0000) begin
        $display("FAIL async_reset sel=%0d: got A=%b B=%b, want 0000/0000", i, OUT_A, OUT_B);
      end else pass_cnt++;
    end
    // Write attempted under reset must be dropped.
    cycle(1'b1, 2'd2, 4'b1111);
    SEL_A = 2'd2;
    #1;
    total_cnt++;
    if (OUT_A !== 4'b0000) begin
      $display("FAIL write_under_reset: got %b, want 0000", OUT_A);
    end else pass_cnt++;
    @(negedge clk);
    write_en = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic test_write_a;
    SEL_A = 2'd0;
    cycle(1'b1, 2'd0, 4'b0001);
    total_cnt++;
    if (OUT_A !== 4'b0001) begin
      $display("FAIL write_a_reg0: got %b, want 0001", OUT_A);
    end else pass_cnt++;
    SEL_A = 2'd1;
    cycle(1'b0, 2'd1, 4'b0001);
    total_cnt++;
    if (OUT_A !== 4'b0000) begin
      $display("FAIL write_a_disabled: got %b, want 0000", OUT_A);
    end else pass_cnt++;
  endtask

  task automatic test_write_b;
    SEL_B = 2'd1;
    cycle(1'b1, 2'd1, 4'b0010);
    total_cnt++;
    if (OUT_B !== 4'b0010) begin
      $display("FAIL write_b_reg1: got %b, want 0010", OUT_B);
    end else pass_cnt++;
    SEL_B = 2'd2;
    cycle(1'b0, 2'd2, 4'b0010);
    total_cnt++;
    if (OUT_B !== 4'b0000) begin
      $display("FAIL write_b_disabled: got %b, want 0000", OUT_B);
    end else pass_cnt++;
  endtask

  task automatic test_one_hot;
    logic [DW-1:0] exp_v [4];
    exp_v[0] = 4'b0001;
    exp_v[1] = 4'b0010;
    exp_v[2] = 4'b0100;
    exp_v[3] = 4'b1000;
    cycle(1'b1, 2'd2, 4'b0100);
    cycle(1'b1, 2'd3, 4'b1000);
    cycle(1'b0, 2'd3, 4'b1111);
    cycle(1'b0, 2'd0, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      SEL_A = AW'(i);
      SEL_B = AW'(i);
      #1;
      total_cnt++;
      if (OUT_A !== exp_v[i] || OUT_B !== exp_v[i]) begin
        $display("FAIL one_hot reg%0d: got A=%b B=%b, want %b", i, OUT_A, OUT_B, exp_v[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_dual_port;
    @(negedge clk);
    SEL_A = 2'd3;
    SEL_B = 2'd3;
    #1;
    total_cnt++;
    if (OUT_A !== 4'b1000 || OUT_B !== 4'b1000) begin
      $display("FAIL dual_same_idx: got A=%b B=%b, want 1000/1000", OUT_A, OUT_B);
    end else pass_cnt++;
    SEL_A = 2'd0;
    SEL_B = 2'd1;
    #1;
    total_cnt++;
    if (OUT_A !== 4'b0001 || OUT_B !== 4'b0010) begin
      $display("FAIL dual_sel_change: got A=%b B=%b, want 0001/0010", OUT_A, OUT_B);
    end else pass_cnt++;
  endtask

  task automatic test_bypass;
    logic [DW-1:0] exp_pre;
`ifdef REG_FILE_BYPASS_EN
    exp_pre = 4'b1010;
`else
    exp_pre = 4'b0100;
`endif
    @(negedge clk);
    write_en = 1'b1;
    SEL_W    = 2'd2;
    DATA_IN  = 4'b1010;
    SEL_A    = 2'd2;
    SEL_B    = 2'd1;
    #1;
    total_cnt++;
    if (OUT_A !== exp_pre) begin
      $display("FAIL bypass_pre_edge: got %b, want %b", OUT_A, exp_pre);
    end else pass_cnt++;
    total_cnt++;
    if (OUT_B !== 4'b0010) begin
      $display("FAIL bypass_other_port: got %b, want 0010", OUT_B);
    end else pass_cnt++;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    SEL_B    = 2'd2;
    #1;
    total_cnt++;
    if (OUT_A !== 4'b1010 || OUT_B !== 4'b1010) begin
      $display("FAIL bypass_post_edge: got A=%b B=%b, want 1010/1010", OUT_A, OUT_B);
    end else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    write_en  = 1'b0;
    SEL_A     = '0;
    SEL_B     = '0;
    SEL_W     = '0;
    DATA_IN   = '0;
    test_reset();
    test_write_a();
    test_write_b();
    test_one_hot();
    test_dual_port();
    test_bypass();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
